pd_request_ctrl: RTL and testbench

//  Initiator side of the power-down handshake: sits between the host command path and the

---
 rtl/pd_request_ctrl_pkg.sv | 21 ++
 rtl/pd_request_ctrl_slot.sv | 44 ++++
 rtl/pd_request_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pd_request_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pd_request_ctrl_pkg.sv
// Shared definitions for the power-down request controller: FSM encoding and command codes.
package pd_request_ctrl_pkg;

    localparam int unsigned CMD_W = 4;

    localparam logic [CMD_W-1:0] CMD_IDLE = 4'h0;
    localparam logic [CMD_W-1:0] CMD_WAKE = 4'h1;

    typedef enum logic [2:0] {
        StActive = 3'd0,
        StReq    = 3'd1,
        StPd     = 3'd2,
        StWake   = 3'd3,
        StExit   = 3'd4
    } pd_state_e;

    function automatic logic is_pd_state(pd_state_e s);
        return (s == StPd) || (s == StWake) || (s == StExit);
    endfunction

endpackage

// File: rtl/pd_request_ctrl_slot.sv
// One-entry valid/ready command register; reads as zero while empty.
module pd_cmd_slot #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             free_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = valid_q ? data_q : '0;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/pd_request_ctrl.sv
// Initiator side of the power-down handshake: forwards host commands, requests power-down
// after an idle period, wakes the responder on new traffic and enforces exit latency.
module pd_request_ctrl
    import pd_request_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_THRESH = 1200,
    parameter int unsigned IDLE_HOT    = 200,
    parameter int unsigned REQ_TIMEOUT = 64,
    parameter int unsigned EXIT_LAT    = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             host_cmd_valid,
    input  logic [CMD_W-1:0] host_cmd,
    output logic             host_cmd_ready,
    output logic             cmd_out_valid,
    output logic [CMD_W-1:0] cmd_out,
    input  logic             cmd_out_ready,
    input  logic             power_down_ready,
    input  logic             power_down_entered,
    input  logic             low_power_mode,
    output logic             enter_power_down,
    output logic             pd_active,
    output logic             pd_timeout,
    output logic [15:0]      pd_entries
);

    localparam int unsigned IdleMax = (IDLE_THRESH > IDLE_HOT) ? IDLE_THRESH : IDLE_HOT;
    localparam int unsigned IdleW   = $clog2(IdleMax + 1);
    localparam int unsigned ReqW    = $clog2(REQ_TIMEOUT + 1);
    localparam int unsigned ExitW   = $clog2(EXIT_LAT + 1);

    pd_state_e        state_d, state_q;
    logic [IdleW-1:0] idle_cnt_d, idle_cnt_q, idle_thr;
    logic [ReqW-1:0]  req_cnt_d, req_cnt_q;
    logic [ExitW-1:0] exit_cnt_d, exit_cnt_q;
    logic             wake_sent_d, wake_sent_q;
    logic [15:0]      pd_entries_d, pd_entries_q;
    logic             pd_timeout_d, pd_timeout_q;
    logic             epd_q, pd_active_q, rdy_en_q;
    logic             slot_load, slot_free;
    logic [CMD_W-1:0] slot_data;
    logic             host_accept, host_nonidle;

    assign idle_thr       = low_power_mode ? IdleW'(IDLE_HOT) : IdleW'(IDLE_THRESH);
    // rdy_en_q keeps ready low during reset and outside ACTIVE
    assign host_cmd_ready = rdy_en_q && slot_free;
    assign host_accept    = host_cmd_valid && host_cmd_ready;
    assign host_nonidle   = host_cmd_valid && (host_cmd != CMD_IDLE);

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = '0;
        req_cnt_d    = req_cnt_q;
        exit_cnt_d   = exit_cnt_q;
        wake_sent_d  = wake_sent_q;
        pd_entries_d = pd_entries_q;
        pd_timeout_d = 1'b0;
        slot_load    = 1'b0;
        slot_data    = host_cmd;
        unique case (state_q)
            StActive: begin
                slot_load  = host_accept && (host_cmd != CMD_IDLE);
                idle_cnt_d = idle_cnt_q;
                if (host_nonidle) begin
                    idle_cnt_d = '0;
                end else if (!host_cmd_valid && !cmd_out_valid && idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                // Never request while a command is being accepted into the slot
                if (idle_cnt_q >= idle_thr && power_down_ready && !cmd_out_valid
                    && !host_cmd_valid) begin
                    state_d   = StReq;
                    req_cnt_d = '0;
                end
            end
            StReq: begin
                if (power_down_entered) begin
                    state_d = StPd;
                    if (pd_entries_q != 16'hFFFF) begin
                        pd_entries_d = pd_entries_q + 16'd1;
                    end
                end else if (host_cmd_valid) begin
                    state_d = StActive;
                end else if (req_cnt_q == ReqW'(REQ_TIMEOUT - 1)) begin
                    state_d      = StActive;
                    pd_timeout_d = 1'b1;
                end else begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
            end
            StPd: begin
                if (host_cmd_valid) begin
                    state_d     = StWake;
                    wake_sent_d = 1'b0;
                end else if (!power_down_entered) begin
                    state_d    = StExit;
                    exit_cnt_d = '0;
                end
            end
            StWake: begin
                if (!wake_sent_q) begin
                    if (!cmd_out_valid) begin
                        slot_load   = 1'b1;
                        slot_data   = CMD_WAKE;
                        wake_sent_d = 1'b1;
                    end
                end else if (cmd_out_valid && cmd_out_ready) begin
                    state_d    = StExit;
                    exit_cnt_d = '0;
                end
            end
            StExit: begin
                if (power_down_entered) begin
                    exit_cnt_d = '0;
                end else if (exit_cnt_q == ExitW'(EXIT_LAT - 1)) begin
                    state_d = StActive;
                end else begin
                    exit_cnt_d = exit_cnt_q + 1'b1;
                end
            end
            default: state_d = StActive;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StActive;
            idle_cnt_q   <= '0;
            req_cnt_q    <= '0;
            exit_cnt_q   <= '0;
            wake_sent_q  <= 1'b0;
            pd_entries_q <= '0;
            pd_timeout_q <= 1'b0;
            epd_q        <= 1'b0;
            pd_active_q  <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            req_cnt_q    <= req_cnt_d;
            exit_cnt_q   <= exit_cnt_d;
            wake_sent_q  <= wake_sent_d;
            pd_entries_q <= pd_entries_d;
            pd_timeout_q <= pd_timeout_d;
            epd_q        <= (state_d == StReq) || (state_d == StPd);
            pd_active_q  <= is_pd_state(state_d);
            rdy_en_q     <= (state_d == StActive);
        end
    end

    pd_cmd_slot #(
        .Width (CMD_W)
    ) u_slot (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .load_i  (slot_load),
        .data_i  (slot_data),
        .ready_i (cmd_out_ready),
        .valid_o (cmd_out_valid),
        .data_o  (cmd_out),
        .free_o  (slot_free)
    );

    assign enter_power_down = epd_q;
    assign pd_active        = pd_active_q;
    assign pd_timeout       = pd_timeout_q;
    assign pd_entries       = pd_entries_q;

endmodule

// File: tb/tb_pd_request_ctrl.sv
// Directed self-checking bench for pd_request_ctrl: forwarding table plus power-down sequences.
module tb_pd_request_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        host_cmd_valid;
    logic [3:0]  host_cmd;
    logic        host_cmd_ready;
    logic        cmd_out_valid;
    logic [3:0]  cmd_out;
    logic        cmd_out_ready;
    logic        power_down_ready;
    logic        power_down_entered;
    logic        low_power_mode;
    logic        enter_power_down;
    logic        pd_active;
    logic        pd_timeout;
    logic [15:0] pd_entries;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    pd_request_ctrl dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .host_cmd_valid     (host_cmd_valid),
        .host_cmd           (host_cmd),
        .host_cmd_ready     (host_cmd_ready),
        .cmd_out_valid      (cmd_out_valid),
        .cmd_out            (cmd_out),
        .cmd_out_ready      (cmd_out_ready),
        .power_down_ready   (power_down_ready),
        .power_down_entered (power_down_entered),
        .low_power_mode     (low_power_mode),
        .enter_power_down   (enter_power_down),
        .pd_active          (pd_active),
        .pd_timeout         (pd_timeout),
        .pd_entries         (pd_entries)
    );

    typedef struct {
        logic       hv;
        logic [3:0] hc;
        logic       ordy;
        logic       exp_rdy;
        logic       exp_ov;
        logic [3:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, 32'(host_cmd_ready), 32'd0);
        check({tag, " out_valid"}, 32'(cmd_out_valid), 32'd0);
        check({tag, " cmd_out"}, 32'(cmd_out), 32'd0);
        check({tag, " epd"}, 32'(enter_power_down), 32'd0);
        check({tag, " pd_active"}, 32'(pd_active), 32'd0);
        check({tag, " pd_timeout"}, 32'(pd_timeout), 32'd0);
        check({tag, " pd_entries"}, 32'(pd_entries), 32'd0);
    endtask

    // Release lands 1ns after a posedge, so the next posedge is the first active edge.
    task automatic do_reset(input logic lpm, input logic pdr);
        sys_rst_n          = 1'b0;
        host_cmd_valid     = 1'b0;
        host_cmd           = 4'h0;
        cmd_out_ready      = 1'b1;
        power_down_entered = 1'b0;
        low_power_mode     = lpm;
        power_down_ready   = pdr;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5};
        vecs[1] = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 4'h5};
        vecs[2] = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 4'h7};
        vecs[3] = '{1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[4] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
        vecs[5] = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF};
        vecs[6] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF};
        vecs[7] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0};

        // Reset state
        sys_rst_n          = 1'b0;
        host_cmd_valid     = 1'b0;
        host_cmd           = 4'h0;
        cmd_out_ready      = 1'b0;
        power_down_ready   = 1'b0;
        power_down_entered = 1'b0;
        low_power_mode     = 1'b0;
        #3;
        check_all_zero("reset");

        // Forwarding table, power-down disabled
        do_reset(1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            host_cmd_valid = vecs[i].hv;
            host_cmd       = vecs[i].hc;
            cmd_out_ready  = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d ready", i), 32'(host_cmd_ready), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(cmd_out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d cmd_out", i), 32'(cmd_out), 32'(vecs[i].exp_out));
        end
        host_cmd_valid = 1'b0;

        // Normal idle threshold: request after 1200 idle cycles, then enter PD
        do_reset(1'b0, 1'b1);
        repeat (1200) tick();
        check("idle1200 epd low", 32'(enter_power_down), 32'd0);
        tick();
        check("idle1200 epd high", 32'(enter_power_down), 32'd1);
        check("req ready low", 32'(host_cmd_ready), 32'd0);
        check("req pd_active", 32'(pd_active), 32'd0);
        power_down_entered = 1'b1;
        tick();
        check("pd pd_active", 32'(pd_active), 32'd1);
        check("pd entries", 32'(pd_entries), 32'd1);
        check("pd epd", 32'(enter_power_down), 32'd1);

        // Wake on host traffic, exit latency, then the held command is forwarded
        host_cmd_valid = 1'b1;
        host_cmd       = 4'h3;
        cmd_out_ready  = 1'b1;
        #1;
        check("pd ready low", 32'(host_cmd_ready), 32'd0);
        for (int i = 0; i < 10 && !cmd_out_valid; i++) tick();
        check("wake valid", 32'(cmd_out_valid), 32'd1);
        check("wake cmd", 32'(cmd_out), 32'h1);
        check("wake epd low", 32'(enter_power_down), 32'd0);
        check("wake pd_active", 32'(pd_active), 32'd1);
        tick();
        check("exit slot empty", 32'(cmd_out_valid), 32'd0);
        power_down_entered = 1'b0;
        repeat (7) tick();
        check("exit hold active", 32'(pd_active), 32'd1);
        check("exit hold ready", 32'(host_cmd_ready), 32'd0);
        tick();
        check("exit done active", 32'(pd_active), 32'd0);
        check("exit done ready", 32'(host_cmd_ready), 32'd1);
        tick();
        check("resume valid", 32'(cmd_out_valid), 32'd1);
        check("resume cmd", 32'(cmd_out), 32'h3);
        host_cmd_valid = 1'b0;
        tick();

        // Hot threshold: request after 200 idle cycles
        do_reset(1'b1, 1'b1);
        repeat (200) tick();
        check("idle200 epd low", 32'(enter_power_down), 32'd0);
        tick();
        check("idle200 epd high", 32'(enter_power_down), 32'd1);

        // REQ timeout with entered held low
        repeat (63) tick();
        check("req63 timeout", 32'(pd_timeout), 32'd0);
        check("req63 epd", 32'(enter_power_down), 32'd1);
        tick();
        check("timeout pulse", 32'(pd_timeout), 32'd1);
        check("timeout epd", 32'(enter_power_down), 32'd0);
        check("timeout active", 32'(pd_active), 32'd0);
        check("timeout entries", 32'(pd_entries), 32'd0);
        tick();
        check("timeout one cycle", 32'(pd_timeout), 32'd0);

        // Host command and entered together in REQ, then async reset in EXIT
        do_reset(1'b1, 1'b1);
        repeat (201) tick();
        check("req2 epd", 32'(enter_power_down), 32'd1);
        host_cmd_valid     = 1'b1;
        host_cmd           = 4'h9;
        power_down_entered = 1'b1;
        tick();
        check("race pd_active", 32'(pd_active), 32'd1);
        check("race entries", 32'(pd_entries), 32'd1);
        check("race epd", 32'(enter_power_down), 32'd1);
        tick();
        check("race wake epd", 32'(enter_power_down), 32'd0);
        tick();
        check("race wake valid", 32'(cmd_out_valid), 32'd1);
        check("race wake cmd", 32'(cmd_out), 32'h1);
        tick();
        check("race exit empty", 32'(cmd_out_valid), 32'd0);
        check("race exit active", 32'(pd_active), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        repeat (2) tick();
        check("reset no wake", 32'(cmd_out_valid), 32'd0);
        host_cmd_valid = 1'b0;
        sys_rst_n      = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
